// File: rtl/pe_intc_pkg.sv
// pe_intc_pkg: shared widths, depth and the response entry type for the peripheral interconnect
package pe_intc_pkg;
  localparam int PE_DATA_W = 32;
  localparam int PE_DEPTH = 4;
  localparam int PE_CNT_W = $clog2(PE_DEPTH + 1);
  typedef struct packed {
    logic opc;
    logic [PE_DATA_W-1:0] rdata;
  } resp_entry_t;
endpackage

// File: rtl/resp_buffer_pe_if.sv
// resp_buffer_pe_if: request/grant and response handshake bundle around resp_buffer_pe
// slave modport: the buffer (takes data_*_i, drives data_*_o); master modport: the surrounding logic
interface resp_buffer_pe_if import pe_intc_pkg::*; #(parameter int DATA_WIDTH = PE_DATA_W) ();
  logic data_req_i;
  logic data_gnt_i;
  logic data_req_o;
  logic data_gnt_o;
  logic data_r_valid_i;
  logic [DATA_WIDTH-1:0] data_r_rdata_i;
  logic data_r_opc_i;
  logic data_r_valid_o;
  logic [DATA_WIDTH-1:0] data_r_rdata_o;
  logic data_r_opc_o;
  logic data_r_ready_i;
  modport slave (
    input data_req_i, data_gnt_i, data_r_valid_i, data_r_rdata_i, data_r_opc_i, data_r_ready_i,
    output data_req_o, data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o
  );
  modport master (
    output data_req_i, data_gnt_i, data_r_valid_i, data_r_rdata_i, data_r_opc_i, data_r_ready_i,
    input data_req_o, data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o
  );
endinterface

// File: rtl/resp_fifo_pe.sv
// resp_fifo_pe: in-order circular response FIFO with optional fall-through
// ports: clk, rst_n (async active-low), i_push/i_data write side, i_pop/o_data read side,
//        o_full, o_empty (nothing presentable at the output), o_count (stored entries)
// RESP_BUFFER_PE_FALLTHROUGH_EN: an empty FIFO presents a pushed entry in the same cycle
module resp_fifo_pe import pe_intc_pkg::*; #(parameter int DEPTH = PE_DEPTH) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  resp_entry_t i_data,
  input  logic i_pop,
  output resp_entry_t o_data,
  output logic o_full,
  output logic o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  resp_entry_t r_mem [DEPTH];
  logic w_none, w_wr, w_rd;
  assign w_none = r_count == '0;
  assign w_rd = i_pop & !w_none;
`ifdef RESP_BUFFER_PE_FALLTHROUGH_EN
  // a bypassed entry consumed in the same cycle never occupies a slot
  assign w_wr = i_push & !(w_none & i_pop);
  assign o_empty = w_none & !i_push;
  assign o_data = w_none ? i_data : r_mem[r_rptr];
`else
  assign w_wr = i_push;
  assign o_empty = w_none;
  assign o_data = r_mem[r_rptr];
`endif
  assign o_full = r_count == CW'(DEPTH);
  assign o_count = r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_mem <= '{default: '0};
    end else begin
      if (w_wr) r_mem[r_wptr] <= i_data;
      r_wptr <= w_wr ? r_wptr + 1'b1 : r_wptr;
      r_rptr <= w_rd ? r_rptr + 1'b1 : r_rptr;
      r_count <= (w_wr & !w_rd) ? r_count + 1'b1 : (w_rd & !w_wr) ? r_count - 1'b1 : r_count;
    end
  end
endmodule

// File: rtl/resp_buffer_pe.sv
// resp_buffer_pe: master-side response buffer with credit-based request throttling
// ports: clk, rst_n (async active-low), bus (resp_buffer_pe_if.slave: req/gnt gating and
//        response valid/ready), outstanding_o (accepted, not yet popped), overflow_o (sticky)
// RESP_BUFFER_PE_FALLTHROUGH_EN: 0-cycle response path when the FIFO is empty
module resp_buffer_pe import pe_intc_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  resp_buffer_pe_if.slave bus,
  output logic [PE_CNT_W-1:0] outstanding_o,
  output logic overflow_o
);
  logic [PE_CNT_W-1:0] r_outstanding, w_fifo_count, w_inflight;
  logic r_overflow;
  logic w_credit, w_accept, w_pop, w_push, w_unexp, w_full, w_empty;
  resp_entry_t w_din, w_dout;
  assign w_credit = r_outstanding < PE_CNT_W'(PE_DEPTH);
  assign bus.data_req_o = bus.data_req_i & w_credit;
  assign bus.data_gnt_o = bus.data_gnt_i & w_credit;
  assign w_accept = bus.data_req_o & bus.data_gnt_i;
  assign w_pop = bus.data_r_valid_o & bus.data_r_ready_i;
  // responses still owed by the tree; a response with none owed is a protocol error
  assign w_inflight = r_outstanding - w_fifo_count;
  assign w_push = bus.data_r_valid_i & (w_inflight != '0) & !w_full;
  assign w_unexp = bus.data_r_valid_i & (w_inflight == '0);
  assign w_din = '{opc: bus.data_r_opc_i, rdata: bus.data_r_rdata_i};
  assign bus.data_r_valid_o = !w_empty;
  assign bus.data_r_rdata_o = w_dout.rdata;
  assign bus.data_r_opc_o = w_dout.opc;
  assign outstanding_o = r_outstanding;
  assign overflow_o = r_overflow;
  resp_fifo_pe #(.DEPTH(PE_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_push(w_push),
    .i_data(w_din),
    .i_pop(w_pop),
    .o_data(w_dout),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(w_fifo_count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_outstanding <= (w_accept & !w_pop) ? r_outstanding + 1'b1 :
                       (w_pop & !w_accept) ? r_outstanding - 1'b1 : r_outstanding;
      r_overflow <= r_overflow | w_unexp;
    end
  end
endmodule

// File: tb/tb_resp_buffer_pe.sv
// tb_resp_buffer_pe: vector table, reset sequence and randomized run against a queue model
module tb_resp_buffer_pe;
  import pe_intc_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [PE_CNT_W-1:0] outstanding;
  logic overflow;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  resp_buffer_pe_if bus ();
  resp_buffer_pe dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .outstanding_o(outstanding),
    .overflow_o(overflow)
  );
  typedef struct {
    logic req, gnt, rv;
    logic [31:0] rd;
    logic opc, rdy;
    logic e_req, e_gnt, e_val;
    logic [31:0] e_rd;
    logic e_opc;
    int e_out;
    logic e_ovf;
  } vec_t;
  vec_t tbl[$];
  resp_entry_t mq[$];
  int m_out;
  logic m_ovf;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic req, gnt, rv, input logic [31:0] rd, input logic opc, rdy);
    bus.data_req_i = req;
    bus.data_gnt_i = gnt;
    bus.data_r_valid_i = rv;
    bus.data_r_rdata_i = rd;
    bus.data_r_opc_i = opc;
    bus.data_r_ready_i = rdy;
  endtask
  task automatic add(input logic req, gnt, rv, input logic [31:0] rd, input logic opc, rdy,
                     input logic e_req, e_gnt, e_val, input logic [31:0] e_rd,
                     input logic e_opc, input int e_out, input logic e_ovf);
    vec_t v;
    v = '{req, gnt, rv, rd, opc, rdy, e_req, e_gnt, e_val, e_rd, e_opc, e_out, e_ovf};
    tbl.push_back(v);
  endtask
  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_valid", bus.data_r_valid_o, 0);
    chk("reset_rdata", bus.data_r_rdata_o, 0);
    chk("reset_opc", bus.data_r_opc_o, 0);
    chk("reset_outstanding", outstanding, 0);
    chk("reset_overflow", overflow, 0);
    drive(1, 1, 0, 0, 0, 0);
    #1;
    chk("reset_req_pass", bus.data_req_o, 1);
    chk("reset_gnt_pass", bus.data_gnt_o, 1);
    // fill to DEPTH, then fifth request is throttled
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, i, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    // four responses stored with ready low, then drained in order
    add(0, 0, 1, 32'hA0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    add(0, 0, 1, 32'hA1, 1, 0, 0, 0, 1, 32'hA0, 0, 4, 0);
    add(0, 0, 1, 32'hA2, 0, 0, 0, 0, 1, 32'hA0, 0, 4, 0);
    add(0, 0, 1, 32'hA3, 1, 0, 0, 0, 1, 32'hA0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hA0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hA1, 1, 3, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hA2, 0, 2, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hA3, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // steady accept+pop every cycle
    add(1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 32'hB0, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 32'hB1, 1, 1, 1, 1, 1, 32'hB0, 0, 2, 0);
    add(1, 1, 1, 32'hB2, 0, 1, 1, 1, 1, 32'hB1, 1, 2, 0);
    add(1, 1, 1, 32'hB3, 1, 1, 1, 1, 1, 32'hB2, 0, 2, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hB3, 1, 2, 0);
    add(0, 0, 1, 32'hB4, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hB4, 0, 1, 0);
    // unexpected response with nothing outstanding
    add(0, 0, 1, 32'hC0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].opc, tbl[i].rdy);
      #1;
      chk($sformatf("vec%0d_req", i), bus.data_req_o, tbl[i].e_req);
      chk($sformatf("vec%0d_gnt", i), bus.data_gnt_o, tbl[i].e_gnt);
      chk($sformatf("vec%0d_valid", i), bus.data_r_valid_o, tbl[i].e_val);
      if (tbl[i].e_val) begin
        chk($sformatf("vec%0d_rdata", i), bus.data_r_rdata_o, tbl[i].e_rd);
        chk($sformatf("vec%0d_opc", i), bus.data_r_opc_o, tbl[i].e_opc);
      end
      chk($sformatf("vec%0d_outstanding", i), outstanding, tbl[i].e_out);
      chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].e_ovf);
      @(negedge clk);
    end
    // three buffered entries, then asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'hD0 + i, 1, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("prerst_valid", bus.data_r_valid_o, 1);
    chk("prerst_outstanding", outstanding, 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.data_r_valid_o, 0);
    chk("async_rst_rdata", bus.data_r_rdata_o, 0);
    chk("async_rst_opc", bus.data_r_opc_o, 0);
    chk("async_rst_outstanding", outstanding, 0);
    chk("async_rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 32'hD3, 0, 1);
    #1;
    chk("post_rst_outstanding", outstanding, 0);
    chk("post_rst_valid", bus.data_r_valid_o, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("stale_resp_overflow", overflow, 1);
    chk("stale_resp_valid", bus.data_r_valid_o, 0);
    chk("stale_resp_outstanding", outstanding, 0);
    // randomized run against a queue model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_out = 0;
    m_ovf = 1'b0;
    mq = {};
    for (int c = 0; c < 3000; c++) begin
      logic req, gnt, rv, opc, rdy, acc, pop;
      logic [31:0] rd;
      int infl;
      resp_entry_t e;
      infl = m_out - mq.size();
      req = $urandom_range(0, 1);
      gnt = $urandom_range(0, 2) != 0;
      rv = infl > 0 ? $urandom_range(0, 2) != 0 : $urandom_range(0, 40) == 0;
      rd = $urandom;
      opc = $urandom_range(0, 1);
      rdy = $urandom_range(0, 4) != 0;
      drive(req, gnt, rv, rd, opc, rdy);
      #1;
      chk("rnd_req", bus.data_req_o, req & (m_out < PE_DEPTH));
      chk("rnd_gnt", bus.data_gnt_o, gnt & (m_out < PE_DEPTH));
      chk("rnd_valid", bus.data_r_valid_o, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("rnd_rdata", bus.data_r_rdata_o, mq[0].rdata);
        chk("rnd_opc", bus.data_r_opc_o, mq[0].opc);
      end
      chk("rnd_outstanding", outstanding, m_out);
      chk("rnd_overflow", overflow, m_ovf);
      acc = req & gnt & (m_out < PE_DEPTH);
      pop = (mq.size() != 0) & rdy;
      if (pop) void'(mq.pop_front());
      if (rv && infl > 0) begin
        e.opc = opc;
        e.rdata = rd;
        mq.push_back(e);
      end
      if (rv && infl == 0) m_ovf = 1'b1;
      m_out = m_out + int'(acc) - int'(pop);
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
